sm4_keyexp_iter: RTL and testbench

Parametrised SM4 key-expansion engine generating the 32 round keys rk0..rk31 from a 128-bit master key, computing UNROLL rounds per clock over 32/UNROLL cycles. It trades area for latency relative to the fully unrolled 32-stage expander. It adds a valid/ready input handshake, a held result with valid flag, and an encrypt/decrypt key-ordering mode. It sits between the key-load interface and the SM4 round datapath, which consumes the 1024-bit RK_o bus.

---
 rtl/sm4_pkg.sv | 73 +++++++
 rtl/sm4_keyexp_round.sv | 21 ++
 rtl/sm4_keyexp_iter.sv | 147 ++++++++++++++
 tb/tb_sm4_keyexp_iter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm4_pkg.sv
// sm4_pkg
// Shared SM4 definitions used by the key-expansion engine and the round
// datapath: key-expansion FSM state type, the FK system parameters, the
// S-box table, the tau / L / L' transforms and the arithmetic CK generator.
// Ports: none (package).
package sm4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } keyexp_state_e;

  // FK0..FK3, FK0 in the top word so it lines up with MK0 in MK[127:96].
  localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

  // SM4 S-box, entry 0x00 in the top byte, one 16-entry row per literal.
  localparam logic [2047:0] SBOX_TABLE = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    return SBOX_TABLE[2047 - 8*int'(x) -: 8];
  endfunction

  // Bytewise S-box substitution of a 32-bit word.
  function automatic logic [31:0] tau_f(input logic [31:0] a);
    return {sbox_f(a[31:24]), sbox_f(a[23:16]), sbox_f(a[15:8]), sbox_f(a[7:0])};
  endfunction

  function automatic logic [31:0] rotl_f(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Linear transform of the encryption round function.
  function automatic logic [31:0] l_f(input logic [31:0] b);
    return b ^ rotl_f(b, 2) ^ rotl_f(b, 10) ^ rotl_f(b, 18) ^ rotl_f(b, 24);
  endfunction

  // Lighter linear transform used only by the key schedule.
  function automatic logic [31:0] l_key_f(input logic [31:0] b);
    return b ^ rotl_f(b, 13) ^ rotl_f(b, 23);
  endfunction

  // CK_i byte j (j=0 is the MSB) is (4i+j)*7 mod 256; the 8-bit product
  // truncation supplies the modulo for free.
  function automatic logic [31:0] ck_f(input logic [4:0] i);
    logic [31:0] ck;
    logic [7:0]  idx;
    ck = '0;
    for (int j = 0; j < 4; j++) begin
      idx = {1'b0, i, 2'(j)};
      ck[31-8*j -: 8] = 8'(idx * 8'd7);
    end
    return ck;
  endfunction

endpackage

// File: rtl/sm4_keyexp_round.sv
// sm4_keyexp_round
// One purely combinational SM4 key-expansion round:
//   rk = K_i ^ L'(tau(K_{i+1} ^ K_{i+2} ^ K_{i+3} ^ CK_i))
// Ports:
//   k0..k3     in  32  window words K_i..K_{i+3}
//   round_idx  in  5   round number i, selects CK_i
//   rk         out 32  round key rk_i (also the next window word K_{i+4})
module sm4_keyexp_round
  import sm4_pkg::*;
(
  input  logic [31:0] k0,
  input  logic [31:0] k1,
  input  logic [31:0] k2,
  input  logic [31:0] k3,
  input  logic [4:0]  round_idx,
  output logic [31:0] rk
);

  assign rk = k0 ^ l_key_f(tau_f(k1 ^ k2 ^ k3 ^ ck_f(round_idx)));

endmodule

// File: rtl/sm4_keyexp_iter.sv
// sm4_keyexp_iter
// Iterative SM4 key expansion: UNROLL chained rounds per clock, producing the
// full 32-word schedule in 32/UNROLL cycles. A key is accepted with a
// valid/ready handshake; the finished schedule is held with a valid flag
// until the next accept, presented in encrypt or decrypt order.
// Ports:
//   CLK_i       in  1     clock
//   RST_N_i     in  1     asynchronous active-low reset
//   MK_i        in  128   master key, MK0 in [127:96]
//   DEC_i       in  1     ordering mode latched on accept (1 = decrypt order)
//   MK_VALID_i  in  1     master key offered
//   MK_READY_o  out 1     engine can accept a key (not expanding)
//   RK_o        out 1024  round keys, first-used key in [1023:992]
//   RK_VALID_o  out 1     RK_o holds a complete schedule
//   BUSY_o      out 1     expansion in progress
module sm4_keyexp_iter
  import sm4_pkg::*;
#(
  parameter int UNROLL = 4
) (
  input  logic          CLK_i,
  input  logic          RST_N_i,
  input  logic [127:0]  MK_i,
  input  logic          DEC_i,
  input  logic          MK_VALID_i,
  output logic          MK_READY_o,
  output logic [1023:0] RK_o,
  output logic          RK_VALID_o,
  output logic          BUSY_o
);

  // Counter value at the start of the final RUN cycle.
  localparam int LAST_RC = 32 - UNROLL;

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 ||
        UNROLL == 16 || UNROLL == 32)) begin : g_bad_unroll
    $error("sm4_keyexp_iter: UNROLL must be one of 1, 2, 4, 8, 16, 32");
  end

  keyexp_state_e state_q;
  keyexp_state_e state_d;
  logic [5:0]    rc_q;
  logic [127:0]  win_q;
  logic [127:0]  win_next;
  logic          dec_q;
  logic [31:0]   rk_q [32];
  logic [31:0]   rk_round [UNROLL];
  logic          accept;

  assign accept = MK_VALID_i & MK_READY_o;

  // Round chain: stage s works on the window slid s times from win_q and
  // handles round rc+s. rc is always a multiple of UNROLL, so rc+s never
  // wraps past 31.
  for (genvar s = 0; s < UNROLL; s++) begin : g_round
    logic [127:0] win_in;
    logic [127:0] win_out;
    logic [31:0]  rk;

    if (s == 0) begin : g_first
      assign win_in = win_q;
    end else begin : g_next
      assign win_in = g_round[s-1].win_out;
    end

    sm4_keyexp_round u_round (
      .k0        (win_in[127:96]),
      .k1        (win_in[95:64]),
      .k2        (win_in[63:32]),
      .k3        (win_in[31:0]),
      .round_idx (rc_q[4:0] + 5'(s)),
      .rk        (rk)
    );

    assign win_out     = {win_in[95:0], rk};
    assign rk_round[s] = rk;

    if (s == UNROLL - 1) begin : g_last
      assign win_next = win_out;
    end
  end

  // State register.
  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: accepts only outside RUN; RUN ends after the cycle that
  // computes the last batch of rounds.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN:  if (rc_q == 6'(LAST_RC)) state_d = ST_DONE;
      ST_DONE: if (accept) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs decode directly from the state.
  always_comb begin
    MK_READY_o = 1'b1;
    BUSY_o     = 1'b0;
    RK_VALID_o = 1'b0;
    case (state_q)
      ST_RUN:  begin MK_READY_o = 1'b0; BUSY_o = 1'b1; end
      ST_DONE: RK_VALID_o = 1'b1;
      default: ;
    endcase
  end

  // Datapath: load the whitened key on accept, otherwise in RUN slide the
  // window by UNROLL words and drop each new round key into its slot. The
  // result register is left alone on accept; it is overwritten as the new
  // schedule is built and RK_VALID_o tells the consumer when it is whole.
  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      win_q <= '0;
      rc_q  <= '0;
      dec_q <= 1'b0;
      for (int i = 0; i < 32; i++) rk_q[i] <= '0;
    end else if (accept) begin
      win_q <= MK_i ^ FK;
      rc_q  <= '0;
      dec_q <= DEC_i;
    end else if (state_q == ST_RUN) begin
      win_q <= win_next;
      rc_q  <= rc_q + 6'(UNROLL);
      for (int i = 0; i < 32; i++) begin
        if (rc_q[4:0] == 5'(i - (i % UNROLL))) rk_q[i] <= rk_round[i % UNROLL];
      end
    end
  end

  // Output ordering: decrypt mode simply reverses the slot order.
  always_comb begin
    RK_o = '0;
    for (int i = 0; i < 32; i++) begin
      RK_o[1023-32*i -: 32] = dec_q ? rk_q[31-i] : rk_q[i];
    end
  end

endmodule

// File: tb/tb_sm4_keyexp_iter.sv
// tb_sm4_keyexp_iter
// Self-checking bench for sm4_keyexp_iter. A behavioural model (whole
// schedule computed at accept time, plus a cycle countdown) is compared
// against the UNROLL=4 DUT on every falling edge; four extra instances cover
// UNROLL = 1, 2, 8, 32 for latency and result equivalence.
`timescale 1ns/1ps
module tb_sm4_keyexp_iter;

  localparam int           U_MAIN  = 4;
  localparam int           LAT     = 32 / U_MAIN;
  localparam logic [127:0] STD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] KEY2    = 128'h00112233445566778899AABBCCDDEEFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [127:0]  mk = '0;
  logic          dec = 1'b0;
  logic          mk_valid = 1'b0;
  logic          sw_mk_valid = 1'b0;
  logic          mk_ready, rk_valid, busy;
  logic [1023:0] rk;
  logic [3:0]    sw_ready, sw_valid, sw_busy;
  logic [1023:0] sw_rk [4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  logic [7:0] tb_sbox [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sm4_keyexp_iter #(.UNROLL(U_MAIN)) u_dut (
    .CLK_i(clk), .RST_N_i(rst_n), .MK_i(mk), .DEC_i(dec), .MK_VALID_i(mk_valid),
    .MK_READY_o(mk_ready), .RK_o(rk), .RK_VALID_o(rk_valid), .BUSY_o(busy));

  sm4_keyexp_iter #(.UNROLL(1)) u_sweep_u1 (
    .CLK_i(clk), .RST_N_i(rst_n), .MK_i(mk), .DEC_i(dec), .MK_VALID_i(sw_mk_valid),
    .MK_READY_o(sw_ready[0]), .RK_o(sw_rk[0]), .RK_VALID_o(sw_valid[0]), .BUSY_o(sw_busy[0]));
  sm4_keyexp_iter #(.UNROLL(2)) u_sweep_u2 (
    .CLK_i(clk), .RST_N_i(rst_n), .MK_i(mk), .DEC_i(dec), .MK_VALID_i(sw_mk_valid),
    .MK_READY_o(sw_ready[1]), .RK_o(sw_rk[1]), .RK_VALID_o(sw_valid[1]), .BUSY_o(sw_busy[1]));
  sm4_keyexp_iter #(.UNROLL(8)) u_sweep_u8 (
    .CLK_i(clk), .RST_N_i(rst_n), .MK_i(mk), .DEC_i(dec), .MK_VALID_i(sw_mk_valid),
    .MK_READY_o(sw_ready[2]), .RK_o(sw_rk[2]), .RK_VALID_o(sw_valid[2]), .BUSY_o(sw_busy[2]));
  sm4_keyexp_iter #(.UNROLL(32)) u_sweep_u32 (
    .CLK_i(clk), .RST_N_i(rst_n), .MK_i(mk), .DEC_i(dec), .MK_VALID_i(sw_mk_valid),
    .MK_READY_o(sw_ready[3]), .RK_o(sw_rk[3]), .RK_VALID_o(sw_valid[3]), .BUSY_o(sw_busy[3]));

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] ck_word(input int i);
    logic [31:0] c;
    c = '0;
    for (int j = 0; j < 4; j++) c = (c << 8) | 32'(((4*i + j) * 7) % 256);
    return c;
  endfunction

  function automatic logic [1023:0] model_expand(input logic [127:0] key, input logic d);
    logic [31:0]   k [36];
    logic [31:0]   fk [4];
    logic [31:0]   x, b;
    logic [1023:0] r;
    int            slot;
    fk = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};
    for (int i = 0; i < 4; i++) k[i] = key[127-32*i -: 32] ^ fk[i];
    for (int i = 0; i < 32; i++) begin
      x = k[i+1] ^ k[i+2] ^ k[i+3] ^ ck_word(i);
      b = {tb_sbox[x[31:24]], tb_sbox[x[23:16]], tb_sbox[x[15:8]], tb_sbox[x[7:0]]};
      k[i+4] = k[i] ^ b ^ rotl(b, 13) ^ rotl(b, 23);
    end
    r = '0;
    for (int i = 0; i < 32; i++) begin
      slot = d ? 31 - i : i;
      r[1023-32*slot -: 32] = k[i+4];
    end
    return r;
  endfunction

  // Cycle model: an accept computes the whole schedule at once; it becomes
  // visible LAT edges later. Ready whenever nothing is counting down.
  logic [1023:0] m_pending, m_rk;
  int            m_left;
  bit            m_valid, m_rk_known;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left     <= 0;
      m_valid    <= 1'b0;
      m_rk       <= '0;
      m_pending  <= '0;
      m_rk_known <= 1'b1;
    end else if (m_left == 0 && mk_valid) begin
      m_pending  <= model_expand(mk, dec);
      m_left     <= LAT;
      m_valid    <= 1'b0;
      m_rk_known <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_valid    <= 1'b1;
        m_rk       <= m_pending;
        m_rk_known <= 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    int w;
    checks++;
    if (act !== exp) begin
      errors++;
      w = 0;
      for (int i = 0; i < 32; i++) if (act[32*i +: 32] !== exp[32*i +: 32]) w = i;
      $display("[TB] FAIL %s: got %h, required %h (word %0d from LSB) at t=%0t",
               name, act[32*w +: 32], exp[32*w +: 32], w, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("ready", 1024'(mk_ready), 1024'(m_left == 0));
      checkOutput("busy", 1024'(busy), 1024'(m_left != 0));
      checkOutput("rk_valid", 1024'(rk_valid), 1024'(m_valid));
      if (m_rk_known) checkOutput("rk", rk, m_rk);
    end
  end

  // ---------------- stimulus ----------------
  int last_acc = 0;

  // Offer a key and hold it until accepted; returns at the falling edge after
  // the accept edge with MK_VALID still high. With scramble set, the key and
  // mode lines carry junk while the engine is busy.
  task automatic applyStimulus(input logic [127:0] key, input logic d, input bit scramble);
    int guard;
    guard = 0;
    mk_valid = 1'b1;
    mk = key;
    dec = d;
    while (!mk_ready && guard < 200) begin
      if (scramble) begin
        mk  = {$urandom, $urandom, $urandom, $urandom};
        dec = 1'($urandom);
      end
      @(negedge clk);
      guard++;
    end
    if (!mk_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_wait: MK_READY_o stayed %b, required 1", mk_ready);
    end
    mk = key;
    dec = d;
    @(posedge clk);
    @(negedge clk);
    last_acc = cyc;
  endtask

  // From the falling edge after an accept, count cycles until RK_VALID_o and
  // the number of sampled cycles with BUSY_o high. Inputs are scrambled
  // meanwhile with MK_VALID low.
  task automatic waitValid(output int lat, output int bw);
    lat = 0;
    bw = busy ? 1 : 0;
    while (!rk_valid && lat < 100) begin
      mk  = {$urandom, $urandom, $urandom, $urandom};
      dec = 1'($urandom);
      @(negedge clk);
      lat++;
      if (busy) bw++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [2047:0] sbox_bits;
    logic [1023:0] exp_rk;
    int lat, bw, n;
    int sw_lat [4];
    int sw_bw [4];
    int sw_u [4];

    sbox_bits = {
      128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948};
    for (int i = 0; i < 256; i++) tb_sbox[i] = sbox_bits[2047-8*i -: 8];
    sw_u = '{1, 2, 8, 32};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    checkOutput("reset_ready", 1024'(mk_ready), 1024'(1));
    checkOutput("reset_valid", 1024'(rk_valid), 1024'(0));
    checkOutput("reset_busy", 1024'(busy), 1024'(0));
    checkOutput("reset_rk", rk, '0);

    // Pin the model to the published test vector.
    exp_rk = model_expand(STD_KEY, 1'b0);
    checkOutput("model_enc_rk0", 1024'(exp_rk[1023:992]), 1024'(32'hF12186F9));
    checkOutput("model_enc_rk1", 1024'(exp_rk[991:960]), 1024'(32'h41662B61));
    checkOutput("model_enc_rk31", 1024'(exp_rk[31:0]), 1024'(32'h9124A012));
    exp_rk = model_expand(STD_KEY, 1'b1);
    checkOutput("model_dec_first", 1024'(exp_rk[1023:992]), 1024'(32'h9124A012));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Standard vector, encrypt order.
    applyStimulus(STD_KEY, 1'b0, 1'b0);
    mk_valid = 1'b0;
    waitValid(lat, bw);
    checkOutput("enc_latency", 1024'(lat), 1024'(LAT));
    checkOutput("enc_busy_width", 1024'(bw), 1024'(LAT));
    checkOutput("enc_rk0", 1024'(rk[1023:992]), 1024'(32'hF12186F9));
    checkOutput("enc_rk1", 1024'(rk[991:960]), 1024'(32'h41662B61));
    checkOutput("enc_rk31", 1024'(rk[31:0]), 1024'(32'h9124A012));

    // Same key, decrypt order; accepted straight out of DONE.
    applyStimulus(STD_KEY, 1'b1, 1'b0);
    mk_valid = 1'b0;
    waitValid(lat, bw);
    checkOutput("dec_latency", 1024'(lat), 1024'(LAT));
    checkOutput("dec_first", 1024'(rk[1023:992]), 1024'(32'h9124A012));
    checkOutput("dec_last", 1024'(rk[31:0]), 1024'(32'hF12186F9));
    repeat (3) @(negedge clk);

    // UNROLL sweep on the side instances.
    mk = STD_KEY;
    dec = 1'b0;
    sw_mk_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sw_mk_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      sw_lat[j] = -1;
      sw_bw[j] = sw_busy[j] ? 1 : 0;
    end
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
        if (sw_valid[j] && sw_lat[j] < 0) sw_lat[j] = n;
        if (sw_busy[j]) sw_bw[j]++;
      end
    end
    exp_rk = model_expand(STD_KEY, 1'b0);
    for (int j = 0; j < 4; j++) begin
      checkOutput($sformatf("sweep_u%0d_latency", sw_u[j]), 1024'(sw_lat[j]), 1024'(32 / sw_u[j]));
      checkOutput($sformatf("sweep_u%0d_busy_width", sw_u[j]), 1024'(sw_bw[j]), 1024'(32 / sw_u[j]));
      checkOutput($sformatf("sweep_u%0d_rk", sw_u[j]), sw_rk[j], exp_rk);
    end

    // A key pulsed mid-RUN is ignored.
    applyStimulus(STD_KEY, 1'b0, 1'b0);
    mk_valid = 1'b0;
    @(negedge clk);
    mk = KEY2;
    mk_valid = 1'b1;
    @(negedge clk);
    mk_valid = 1'b0;
    waitValid(lat, bw);
    checkOutput("pulse_ignored_latency", 1024'(lat), 1024'(LAT - 2));
    checkOutput("pulse_ignored_rk0", 1024'(rk[1023:992]), 1024'(32'hF12186F9));

    // A second key held through RUN restarts the engine from DONE.
    applyStimulus(STD_KEY, 1'b0, 1'b0);
    applyStimulus(KEY2, 1'b0, 1'b0);
    mk_valid = 1'b0;
    waitValid(lat, bw);
    checkOutput("held_restart_latency", 1024'(lat), 1024'(LAT));
    exp_rk = model_expand(KEY2, 1'b0);
    checkOutput("held_restart_rk", rk, exp_rk);

    // Reset in the third RUN cycle.
    applyStimulus(STD_KEY, 1'b0, 1'b0);
    mk_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_reset_ready", 1024'(mk_ready), 1024'(1));
    checkOutput("midrun_reset_valid", 1024'(rk_valid), 1024'(0));
    checkOutput("midrun_reset_busy", 1024'(busy), 1024'(0));
    checkOutput("midrun_reset_rk", rk, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      checkOutput("no_valid_after_reset", 1024'(rk_valid), 1024'(0));
    end
    applyStimulus(STD_KEY, 1'b0, 1'b0);
    mk_valid = 1'b0;
    waitValid(lat, bw);
    checkOutput("post_reset_latency", 1024'(lat), 1024'(LAT));
    checkOutput("post_reset_rk0", 1024'(rk[1023:992]), 1024'(32'hF12186F9));

    // Random keys, back-to-back, both modes.
    for (int k = 0; k < 1000; k++) begin
      n = last_acc;
      applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'($urandom), 1'b1);
      if (k > 0) checkOutput("throughput_period", 1024'(last_acc - n), 1024'(LAT + 1));
    end
    mk_valid = 1'b0;
    waitValid(lat, bw);
    checkOutput("final_latency", 1024'(lat), 1024'(LAT));
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
